// File: rtl/rd_mon_pkg.sv
// ---------------------------------------------------------------------------
// rd_mon_pkg
// Shared types and helpers for the read-path latency watchdog bank.
//   slot_state_e : per-slot lifecycle of one outstanding read
//   idx_width()  : width of a slot index for a given number of slots
// ---------------------------------------------------------------------------
package rd_mon_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'b00,
        FIRST   = 2'b01,
        BURST   = 2'b10,
        EXPIRED = 2'b11
    } slot_state_e;

    // A single slot still needs a 1-bit index port so the interface stays uniform.
    function automatic int idx_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/rd_budget_slot.sv
// ---------------------------------------------------------------------------
// rd_budget_slot
// One read-latency watchdog: a lifecycle FSM plus a down-counting budget.
// The slot is armed by an allocation, counts en_i ticks while waiting for
// read data, optionally reloads on every non-last beat and is released by
// the last beat or, once expired, by a software clear.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FREE    | no read tracked; counter parked at 0
// FIRST   | armed, waiting for the first R beat (alloc budget running)
// BURST   | at least one beat seen, waiting for the next/last beat
// EXPIRED | budget ran out; counter frozen until last beat or clear
//
// Ports
//   clk_i, rst_ni   clock, synchronous active-low reset
//   en_i            count enable (prescaler tick)
//   alloc_hit_i     this slot is being allocated this cycle
//   beat_hit_i      an R handshake belongs to this slot this cycle
//   last_i          the R handshake carries RLAST
//   clr_i           software ack of an expired slot
//   alloc_budget_i  budget loaded on allocation
//   beat_budget_i   budget loaded on each non-last beat (ReloadPerBeat=1)
//   state_o         registered slot state
//   spurious_o      beat aimed at a free slot (combinational event)
//   late_o          last beat completed an expired slot (combinational event)
//   alloc_err_o     allocation aimed at a busy slot (combinational event)
// ---------------------------------------------------------------------------
module rd_budget_slot
    import rd_mon_pkg::*;
#(
    parameter int CntWidth      = 10,
    parameter bit ReloadPerBeat = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                alloc_hit_i,
    input  logic                beat_hit_i,
    input  logic                last_i,
    input  logic                clr_i,
    input  logic [CntWidth-1:0] alloc_budget_i,
    input  logic [CntWidth-1:0] beat_budget_i,
    output slot_state_e         state_o,
    output logic                spurious_o,
    output logic                late_o,
    output logic                alloc_err_o
);

    slot_state_e         state_d, state_q;
    logic [CntWidth-1:0] cnt_d, cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        spurious_o  = 1'b0;
        late_o      = 1'b0;
        alloc_err_o = 1'b0;

        case (state_q)
            FREE: begin
                if (alloc_hit_i) begin
                    state_d = FIRST;
                    cnt_d   = alloc_budget_i;
                end
                if (beat_hit_i) begin
                    spurious_o = 1'b1;
                end
            end

            FIRST, BURST: begin
                // Decided on the state at cycle start, so a slot being
                // released this cycle still rejects a new allocation.
                alloc_err_o = alloc_hit_i;
                if (beat_hit_i && last_i) begin
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (beat_hit_i) begin
                    // A beat outranks expiry: it rescues a slot sitting at 0.
                    state_d = BURST;
                    if (ReloadPerBeat) begin
                        cnt_d = beat_budget_i;
                    end
                end else if (cnt_q == '0) begin
                    state_d = EXPIRED;
                end else if (en_i) begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end

            EXPIRED: begin
                alloc_err_o = alloc_hit_i;
                if (beat_hit_i && last_i) begin
                    state_d = FREE;
                    late_o  = 1'b1;
                end else if (clr_i) begin
                    state_d = FREE;
                end
            end

            default: begin
                state_d = FREE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= FREE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rd_budget_counter_bank.sv
// ---------------------------------------------------------------------------
// rd_budget_counter_bank
// Bank of NumSlots read-latency watchdogs for the AXI monitor read path.
// Each outstanding AR owns one slot; the slot times the wait for read data
// and latches an expiry until software acknowledges it or the read ends.
//
// Ports
//   clk_i, rst_ni     clock, synchronous active-low reset
//   en_i              global count enable (prescaler tick)
//   alloc_valid_i     arm slot alloc_idx_i with alloc_budget_i
//   alloc_idx_i       slot to arm
//   alloc_budget_i    first-beat budget in en_i ticks
//   beat_budget_i     inter-beat budget (used when ReloadPerBeat=1)
//   r_hs_i            R handshake this cycle
//   r_last_i          RLAST of that handshake
//   r_idx_i           slot owning the R beat
//   clr_i             per-slot clear of an expired slot
//   busy_o            slot is not FREE
//   timeout_o         slot is EXPIRED (sticky)
//   timeout_irq_o     any slot expired
//   alloc_err_o       pulse: allocation to a busy slot
//   spurious_o        pulse: R beat to a free slot
//   late_o            pulse: last beat completed an expired slot
// ---------------------------------------------------------------------------
module rd_budget_counter_bank
    import rd_mon_pkg::*;
#(
    parameter int  NumSlots      = 8,
    parameter int  CntWidth      = 10,
    parameter bit  ReloadPerBeat = 1'b1,
    localparam int IdxWidth      = idx_width(NumSlots)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                alloc_valid_i,
    input  logic [IdxWidth-1:0] alloc_idx_i,
    input  logic [CntWidth-1:0] alloc_budget_i,
    input  logic [CntWidth-1:0] beat_budget_i,
    input  logic                r_hs_i,
    input  logic                r_last_i,
    input  logic [IdxWidth-1:0] r_idx_i,
    input  logic [NumSlots-1:0] clr_i,
    output logic [NumSlots-1:0] busy_o,
    output logic [NumSlots-1:0] timeout_o,
    output logic                timeout_irq_o,
    output logic                alloc_err_o,
    output logic                spurious_o,
    output logic                late_o
);

    logic [NumSlots-1:0] alloc_hit;
    logic [NumSlots-1:0] beat_hit;
    logic [NumSlots-1:0] slot_spurious;
    logic [NumSlots-1:0] slot_late;
    logic [NumSlots-1:0] slot_alloc_err;
    slot_state_e         slot_state [NumSlots];

    // Indices beyond NumSlots-1 (non power-of-two banks) match no slot.
    for (genvar s = 0; s < NumSlots; s++) begin : g_slot
        assign alloc_hit[s] = alloc_valid_i && (alloc_idx_i == IdxWidth'(s));
        assign beat_hit[s]  = r_hs_i && (r_idx_i == IdxWidth'(s));

        rd_budget_slot #(
            .CntWidth      (CntWidth),
            .ReloadPerBeat (ReloadPerBeat)
        ) u_slot (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .en_i           (en_i),
            .alloc_hit_i    (alloc_hit[s]),
            .beat_hit_i     (beat_hit[s]),
            .last_i         (r_last_i),
            .clr_i          (clr_i[s]),
            .alloc_budget_i (alloc_budget_i),
            .beat_budget_i  (beat_budget_i),
            .state_o        (slot_state[s]),
            .spurious_o     (slot_spurious[s]),
            .late_o         (slot_late[s]),
            .alloc_err_o    (slot_alloc_err[s])
        );
    end

    always_comb begin
        busy_o    = '0;
        timeout_o = '0;
        for (int s = 0; s < NumSlots; s++) begin
            busy_o[s]    = (slot_state[s] != FREE);
            timeout_o[s] = (slot_state[s] == EXPIRED);
        end
    end

    assign timeout_irq_o = |timeout_o;

    logic alloc_err_d, alloc_err_q;
    logic spurious_d,  spurious_q;
    logic late_d,      late_q;

    always_comb begin
        alloc_err_d = |slot_alloc_err;
        spurious_d  = |slot_spurious;
        late_d      = |slot_late;
    end

    // Reset clears the pulse registers too, so events from slots discarded
    // by a reset never reach the outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            alloc_err_q <= 1'b0;
            spurious_q  <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            alloc_err_q <= alloc_err_d;
            spurious_q  <= spurious_d;
            late_q      <= late_d;
        end
    end

    assign alloc_err_o = alloc_err_q;
    assign spurious_o  = spurious_q;
    assign late_o      = late_q;

endmodule

// File: tb/tb_rd_budget_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_rd_budget_counter_bank
// Two banks share one stimulus stream: index 0 holds the counter on beats,
// index 1 reloads it. Both are compared every cycle against a reference
// model that tracks per slot only "busy", "expired" and remaining ticks.
// ---------------------------------------------------------------------------
module tb_rd_budget_counter_bank;

    localparam int NS = 8;
    localparam int CW = 10;
    localparam int IW = 3;

    logic          clk_i;
    logic          rst_ni;
    logic          en_i;
    logic          alloc_valid_i;
    logic [IW-1:0] alloc_idx_i;
    logic [CW-1:0] alloc_budget_i;
    logic [CW-1:0] beat_budget_i;
    logic          r_hs_i;
    logic          r_last_i;
    logic [IW-1:0] r_idx_i;
    logic [NS-1:0] clr_i;

    logic [NS-1:0] busy [2];
    logic [NS-1:0] tmo  [2];
    logic          irq  [2];
    logic          aerr [2];
    logic          spur [2];
    logic          late [2];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    rd_budget_counter_bank #(.NumSlots(NS), .CntWidth(CW), .ReloadPerBeat(1'b0)) dut_hold (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .alloc_valid_i(alloc_valid_i), .alloc_idx_i(alloc_idx_i),
        .alloc_budget_i(alloc_budget_i), .beat_budget_i(beat_budget_i),
        .r_hs_i(r_hs_i), .r_last_i(r_last_i), .r_idx_i(r_idx_i), .clr_i(clr_i),
        .busy_o(busy[0]), .timeout_o(tmo[0]), .timeout_irq_o(irq[0]),
        .alloc_err_o(aerr[0]), .spurious_o(spur[0]), .late_o(late[0])
    );

    rd_budget_counter_bank #(.NumSlots(NS), .CntWidth(CW), .ReloadPerBeat(1'b1)) dut_reload (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .alloc_valid_i(alloc_valid_i), .alloc_idx_i(alloc_idx_i),
        .alloc_budget_i(alloc_budget_i), .beat_budget_i(beat_budget_i),
        .r_hs_i(r_hs_i), .r_last_i(r_last_i), .r_idx_i(r_idx_i), .clr_i(clr_i),
        .busy_o(busy[1]), .timeout_o(tmo[1]), .timeout_irq_o(irq[1]),
        .alloc_err_o(aerr[1]), .spurious_o(spur[1]), .late_o(late[1])
    );

    // ---------------- reference model ----------------
    bit m_busy [2][NS];
    bit m_exp  [2][NS];
    int m_rem  [2][NS];
    bit m_aerr [2];
    bit m_spur [2];
    bit m_late [2];

    function automatic void model_step();
        for (int m = 0; m < 2; m++) begin
            m_aerr[m] = 1'b0;
            m_spur[m] = 1'b0;
            m_late[m] = 1'b0;
            for (int s = 0; s < NS; s++) begin
                bit a_hit;
                bit b_hit;
                if (!rst_ni) begin
                    m_busy[m][s] = 1'b0;
                    m_exp[m][s]  = 1'b0;
                    m_rem[m][s]  = 0;
                    continue;
                end
                a_hit = alloc_valid_i && (int'(alloc_idx_i) == s);
                b_hit = r_hs_i && (int'(r_idx_i) == s);
                if (!m_busy[m][s]) begin
                    if (b_hit) m_spur[m] = 1'b1;
                    if (a_hit) begin
                        m_busy[m][s] = 1'b1;
                        m_rem[m][s]  = int'(alloc_budget_i);
                    end
                end else if (m_exp[m][s]) begin
                    if (a_hit) m_aerr[m] = 1'b1;
                    if (b_hit && r_last_i) begin
                        m_busy[m][s] = 1'b0;
                        m_exp[m][s]  = 1'b0;
                        m_late[m]    = 1'b1;
                    end else if (clr_i[s]) begin
                        m_busy[m][s] = 1'b0;
                        m_exp[m][s]  = 1'b0;
                    end
                end else begin
                    if (a_hit) m_aerr[m] = 1'b1;
                    if (b_hit && r_last_i) begin
                        m_busy[m][s] = 1'b0;
                        m_rem[m][s]  = 0;
                    end else if (b_hit) begin
                        if (m == 1) m_rem[m][s] = int'(beat_budget_i);
                    end else if (m_rem[m][s] == 0) begin
                        m_exp[m][s] = 1'b1;
                    end else if (en_i) begin
                        m_rem[m][s] = m_rem[m][s] - 1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [NS-1:0] exp_busy(input int m);
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = m_busy[m][s];
        return v;
    endfunction

    function automatic logic [NS-1:0] exp_tmo(input int m);
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = m_exp[m][s];
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got 0x%0h want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("busy_m%0d", m),  32'(busy[m]), 32'(exp_busy(m)));
            chk($sformatf("tmo_m%0d", m),   32'(tmo[m]),  32'(exp_tmo(m)));
            chk($sformatf("irq_m%0d", m),   32'(irq[m]),  32'(|exp_tmo(m)));
            chk($sformatf("aerr_m%0d", m),  32'(aerr[m]), 32'(m_aerr[m]));
            chk($sformatf("spur_m%0d", m),  32'(spur[m]), 32'(m_spur[m]));
            chk($sformatf("late_m%0d", m),  32'(late[m]), 32'(m_late[m]));
        end
    endtask

    // Inputs are set #1 after an edge; the model consumes them, then the
    // edge happens and outputs are compared #1 later.
    task automatic cycle();
        model_step();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst_ni         = 1'b1;
        en_i           = 1'b1;
        alloc_valid_i  = 1'b0;
        alloc_idx_i    = '0;
        alloc_budget_i = '0;
        beat_budget_i  = '0;
        r_hs_i         = 1'b0;
        r_last_i       = 1'b0;
        r_idx_i        = '0;
        clr_i          = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        cycle();
        rst_ni = 1'b1;
    endtask

    task automatic alloc(input int idx, input int budget);
        alloc_valid_i  = 1'b1;
        alloc_idx_i    = IW'(idx);
        alloc_budget_i = CW'(budget);
        cycle();
        alloc_valid_i  = 1'b0;
    endtask

    task automatic beat(input int idx, input bit last, input int bb);
        r_hs_i        = 1'b1;
        r_last_i      = last;
        r_idx_i       = IW'(idx);
        beat_budget_i = CW'(bb);
        cycle();
        r_hs_i        = 1'b0;
        r_last_i      = 1'b0;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        cycle();
        cycle();
        chk("rst_busy", 32'(busy[1] | busy[0]), 32'h0);
        chk("rst_tmo",  32'(tmo[1] | tmo[0]), 32'h0);
        rst_ni = 1'b1;

        // Slot 2, budget 5: expires on the 6th edge after the alloc edge.
        alloc(2, 5);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk("t1_pre_tmo", 32'(tmo[1]), 32'h0);
        end
        cycle();
        chk("t1_tmo",  32'(tmo[1]), 32'h04);
        chk("t1_tmo0", 32'(tmo[0]), 32'h04);
        chk("t1_irq",  32'(irq[1]), 32'h1);
        clr_i = 8'h04;
        cycle();
        clr_i = '0;
        chk("t1_clr_busy", 32'(busy[1][2]), 32'h0);
        chk("t1_clr_irq",  32'(irq[1]), 32'h0);

        // Slot 0, budget 3, non-last beat on edge 2, last on edge 5.
        do_reset();
        alloc(0, 3);
        cycle();
        beat(0, 1'b0, 4);
        cycle();
        cycle();
        chk("t2_busy_before", 32'(busy[1][0]), 32'h1);
        beat(0, 1'b1, 4);
        chk("t2_busy_after_r", 32'(busy[1][0]), 32'h0);
        chk("t2_busy_after_h", 32'(busy[0][0]), 32'h0);
        chk("t2_no_tmo", 32'(tmo[0] | tmo[1]), 32'h0);

        // Hold mode: budget 3, beat on edge 1 holds 3, then 3->0 over three
        // edges and expiry on edge 5; the reload bank got 6 and is still busy.
        do_reset();
        alloc(0, 3);
        beat(0, 1'b0, 6);
        for (int k = 2; k <= 4; k++) begin
            cycle();
            chk("t3_pre_tmo", 32'(tmo[0][0]), 32'h0);
        end
        cycle();
        chk("t3_tmo_hold",   32'(tmo[0][0]), 32'h1);
        chk("t3_tmo_reload", 32'(tmo[1][0]), 32'h0);
        beat(0, 1'b1, 0);
        chk("t3_late_hold",   32'(late[0]), 32'h1);
        chk("t3_late_reload", 32'(late[1]), 32'h0);

        // Double allocation and spurious beat.
        do_reset();
        alloc(1, 10);
        alloc(1, 2);
        chk("t4_aerr", 32'(aerr[1]), 32'h1);
        cycle();
        chk("t4_aerr_clear", 32'(aerr[1]), 32'h0);
        beat(3, 1'b0, 0);
        chk("t4_spur", 32'(spur[1]), 32'h1);
        for (int k = 0; k < 4; k++) cycle();
        chk("t4_not_reloaded", 32'(tmo[1][1]), 32'h0);
        beat(1, 1'b1, 0);

        // Zero budget, late completion, rescue at cnt==0.
        do_reset();
        alloc(4, 0);
        cycle();
        chk("t5_tmo", 32'(tmo[1]), 32'h10);
        beat(4, 1'b1, 0);
        chk("t5_late", 32'(late[1]), 32'h1);
        chk("t5_free", 32'(busy[1][4]), 32'h0);
        alloc(4, 2);
        cycle();
        cycle();
        beat(4, 1'b0, 3);
        chk("t5_rescue", 32'(tmo[0][4] | tmo[1][4]), 32'h0);
        cycle();
        beat(4, 1'b1, 0);

        // Sparse enable: one tick in four, budget 2.
        do_reset();
        alloc(5, 2);
        for (int k = 1; k <= 12; k++) begin
            en_i = (k % 4 == 1);
            cycle();
        end
        en_i = 1'b1;
        chk("t6_tmo", 32'(tmo[1][5]), 32'h1);

        // Reset with busy slots and a colliding allocation pending.
        do_reset();
        alloc(0, 50);
        alloc(1, 50);
        alloc(2, 50);
        rst_ni        = 1'b0;
        alloc_valid_i = 1'b1;
        alloc_idx_i   = 3'd0;
        cycle();
        alloc_valid_i = 1'b0;
        rst_ni        = 1'b1;
        chk("t7_busy", 32'(busy[1]), 32'h0);
        chk("t7_aerr", 32'(aerr[1]), 32'h0);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_ni         = ($urandom_range(0, 399) != 0);
            en_i           = ($urandom_range(0, 2) != 0);
            alloc_valid_i  = ($urandom_range(0, 3) == 0);
            alloc_idx_i    = IW'($urandom_range(0, NS - 1));
            alloc_budget_i = CW'($urandom_range(0, 6));
            beat_budget_i  = CW'($urandom_range(0, 6));
            r_hs_i         = ($urandom_range(0, 2) == 0);
            r_last_i       = ($urandom_range(0, 2) == 0);
            r_idx_i        = IW'($urandom_range(0, NS - 1));
            if (alloc_valid_i && r_hs_i && (r_idx_i == alloc_idx_i)) begin
                r_idx_i = r_idx_i + IW'(1);
            end
            clr_i = ($urandom_range(0, 4) == 0) ? NS'($urandom) : '0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
